// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded instruction (operands, register indices, ALU and
// memory/writeback controls) on each rising clock edge and presents it to
// the execute stage. A bubble replaces the captured instruction when a
// taken branch/jump flushes the pipe, or when the instruction in ID reads
// a register that a load currently in EX has not yet produced.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   id_*              decoded instruction fields from the decode stage
//   flush             taken branch/jump resolved in EX; kills the ID slot
//   load_use_stall    hold PC and IF/ID this cycle (combinational)
//   ex_valid, ex_*    registered copies of the id_* fields for EX
//   bubble_count      saturating count of bubbles inserted since reset
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              flush,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs1,
  output logic [REG_W-1:0]  ex_rs2,
  output logic [REG_W-1:0]  ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [CNT_W-1:0]  bubble_count
);

  logic haz;
  logic rs1_match;
  logic rs2_match;
  logic bubble;

  // Hazard is derived only from registered EX state and the current ID
  // slot, so a stall lasts one cycle: the bubble it inserts clears ex_valid.
  always_comb begin
    rs1_match      = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_match      = id_uses_rs2 && (id_rs2 == ex_rd);
    haz            = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                     && (rs1_match || rs2_match);
    // A flushed ID instruction is discarded anyway, so it must not stall.
    load_use_stall = haz && !flush;
    bubble         = flush || load_use_stall;
  end

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rd1        <= '0;
      ex_rd2        <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_funct3     <= '0;
      ex_funct7     <= '0;
      ex_alu_op     <= '0;
      ex_alu_src    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
    end else begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_rd1        <= id_rd1;
      ex_rd2        <= id_rd2;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_funct3     <= id_funct3;
      ex_funct7     <= id_funct7;
      ex_alu_op     <= id_alu_op;
      ex_alu_src    <= id_alu_src;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_reg_write  <= id_reg_write;
      ex_branch     <= id_branch;
      ex_jump       <= id_jump;
    end
  end

  // Saturating bubble counter; simultaneous flush and hazard count once.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_count <= '0;
    end else if (bubble && (bubble_count != '1)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection. It captures decoded control and operands from the decode stage and presents them to the execute stage. The ALU operation controller in EX consumes its ex_alu_op/ex_funct3/ex_funct7 outputs directly. It inserts bubbles on branch/jump flush and on load-use hazards, and keeps a saturating bubble counter for performance debug.

Parameters:
DATA_W, 32, operand/immediate width
PC_W, 9, program counter width
REG_W, 5, register index width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_pc  in  PC_W  PC of ID instruction
id_rd1  in  DATA_W  rs1 read data
id_rd2  in  DATA_W  rs2 read data
id_imm  in  DATA_W  sign-extended immediate
id_rs1  in  REG_W  source register 1 index
id_rs2  in  REG_W  source register 2 index
id_uses_rs1  in  1  instruction reads rs1
id_uses_rs2  in  1  instruction reads rs2
id_rd  in  REG_W  destination index
id_funct3  in  3  instr[14:12]
id_funct7  in  7  instr[31:25]
id_alu_op  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI
id_alu_src  in  1  ALU B operand select: immediate
id_mem_read  in  1  load
id_mem_write  in  1  store
id_mem_to_reg  in  1  writeback from memory
id_reg_write  in  1  register writeback enable
id_branch  in  1  conditional branch
id_jump  in  1  JAL/JALR
flush  in  1  branch/jump taken, resolved in EX
load_use_stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch, ex_jump  out  same widths as id_ counterparts  registered copies
bubble_count  out  CNT_W  bubbles inserted since reset

Behaviour:
- Reset: every ex_* output is 0, including ex_valid and ex_alu_op=00. bubble_count=0. load_use_stall is therefore 0 during the cycle after reset.
- Reset overrides flush and stall. Reset asserted mid-stream clears everything at the next edge; in-flight state is not preserved.
- Hazard (combinational, from registered EX state):
  - haz = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - load_use_stall = haz & ~flush. A killed ID instruction never stalls.
- Edge priority: reset > flush > load_use_stall > load.
  - flush or load_use_stall: insert a bubble. All ex_* outputs become 0 (ex_valid=0, no writes, alu_op=00, data fields 0).
  - Otherwise: all ex_* take their id_* values and ex_valid=id_valid. Control fields pass unchanged even when id_valid=0. The ID stage zeroes its own controls for invalid slots.
- Latency: exactly one cycle from ID to EX. No combinational path from id_* to ex_*.
- A load-use stall lasts exactly one cycle. The next cycle EX holds a bubble (ex_valid=0), so haz=0 and the held ID instruction loads.
- bubble_count increments by 1 on each edge where flush|load_use_stall and reset=0. Simultaneous flush and hazard count once. The counter saturates at 2^CNT_W-1 and never wraps. Only reset clears it.
- The block has no internal FSM beyond the register and counter. Stall/bubble sequencing emerges from the hazard equation.

Test Plan:
- Pass-through: id_valid=1, alu_op=10, funct3=000, funct7=0100000, rd1=5, rd2=3, rd=7 -> next edge ex_alu_op=10, ex_funct7=0x20, ex_rd1=5, ex_rd2=3, ex_rd=7, ex_valid=1; load_use_stall=0 throughout.
- Load-use: EX holds lw (mem_read=1, rd=5, valid); ID has add with rs1=5 and uses_rs1=1 -> load_use_stall=1 that cycle. Next edge: ex_valid=0, ex_reg_write=0, bubble_count=1, load_use_stall=0. Following edge: add in EX with ex_rs1=5.
- No false stall: a load to rd=0 followed by a user of rs1=0 -> stall=0. A load to rd=6 followed by an I-type with rs2=6 and uses_rs2=0 -> stall=0.
- Flush collides with hazard: hazard conditions true and flush=1 -> load_use_stall=0. Next edge produces a bubble and bubble_count increments by exactly 1.
- Reset mid-operation: after three valid loads, assert reset for one cycle -> all ex_* = 0, ex_alu_op=00, bubble_count=0 at that edge. Normal capture resumes the edge after deassertion.
- Saturation (CNT_W=4 override): apply 20 consecutive flush cycles -> bubble_count reaches 15 and holds at 15.
